// File: rtl/processor_pkg.sv
// ============================================================================
// processor_pkg: shared state encoding and defaults for the run controller.
// Rev 1.0
// ============================================================================
`default_nettype none

package processor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RESET = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/processor_run_ctrl.sv
// ============================================================================
// processor_run_ctrl: reset/run sequencer for the processor core with cycle
// budget, halt detection and single-step support.
// Rev 1.0
// ============================================================================
`default_nettype none

module processor_run_ctrl
  import processor_pkg::*;
#(
  parameter int RST_CYCLES = 1,
  parameter int MAX_CYCLES = 25,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt_in,
  output logic             core_rst,
  output logic             run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int              c_rc_w    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_rc_w-1:0] c_rst_load = c_rc_w'(RST_CYCLES - 1);
  // Count value seen during the final budgeted cycle; unused when unlimited.
  localparam logic [CNT_W-1:0] c_last   = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  logic [1:0]        r_state;
  logic [c_rc_w-1:0] r_rst_cnt;
  logic              r_done;
  logic              r_timeout;

  logic w_run;
  logic w_halt;
  logic w_last;
  logic w_begin;
  logic w_clr;

  assign w_run   = (r_state == ST_RUN) && (!step_mode || step);
  assign w_halt  = w_run && halt_in;
  assign w_last  = (MAX_CYCLES != 0) && w_run && (cycle_count == c_last);
  assign w_begin = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_clr   = abort || w_begin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (abort) begin
      r_state   <= ST_IDLE;
      r_rst_cnt <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_RESET;
            r_rst_cnt <= c_rst_load;
          end
        end
        ST_RESET: begin
          if (r_rst_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_rst_cnt <= r_rst_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          // Halt outranks budget exhaustion in the same cycle.
          if (w_halt) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
          end else if (w_last) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state   <= ST_RESET;
            r_rst_cnt <= c_rst_load;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_run),
    .count (cycle_count)
  );

  assign core_rst = (r_state == ST_IDLE) || (r_state == ST_RESET);
  assign busy     = (r_state == ST_RESET) || (r_state == ST_RUN);
  assign run      = w_run;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule

`default_nettype wire
